// File: rtl/mips_cpu_fetch.sv
// MIPS instruction fetch unit: Avalon-style read master feeding the decoder, with branch-delay-slot sequencing.
// Optional macro FETCH_ALIGN_CHECK_EN: halt with a sticky fetch_fault on an unaligned next address.
module mips_cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic [1:0]  CtrlPC,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_out,
    output logic [31:0] link_addr,
    output logic        active
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int unsigned    AW         = 32;
    localparam logic [AW-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_HOLD,
        ST_HALTED
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_npc;
    logic [AW-1:0] r_pend;
    logic          r_target_valid;

    logic [AW-1:0] w_pc4;
    logic [AW-1:0] w_br_target;
    logic [AW-1:0] w_j_target;
    logic [AW-1:0] w_target;
    logic [AW-1:0] w_next_raw;
    logic [AW-1:0] w_next;
    logic [AW-1:0] w_pend_next;
    logic          w_redirect;
    logic          w_fault;
    logic          w_halt;

    assign w_pc4       = r_pc + 32'd4;
    assign w_br_target = w_pc4 + {{14{Instr[15]}}, Instr[15:0], 2'b00};
    assign w_j_target  = {w_pc4[31:28], Instr[25:0], 2'b00};
    assign w_redirect  = (CtrlPC != 2'd0);

    // Redirect target selected by the decoder
    always_comb begin
        w_target = w_pc4;
        case (CtrlPC)
            2'd1:    w_target = w_br_target;
            2'd2:    w_target = w_j_target;
            2'd3:    w_target = jr_target;
            default: w_target = w_pc4;
        endcase
    end

    // A redirect first sequences its delay slot; the target waits in r_pend
    assign w_next_raw = w_redirect     ? w_pc4  :
                        r_target_valid ? r_pend : r_npc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_fault     = (w_next_raw[1:0] != 2'b00) || (w_redirect && (w_target[1:0] != 2'b00));
    assign w_next      = w_next_raw;
    assign w_pend_next = w_target;
`else
    assign w_fault     = 1'b0;
    assign w_next      = w_next_raw & ALIGN_MASK;
    assign w_pend_next = w_target & ALIGN_MASK;
`endif

    assign w_halt    = w_fault || (w_next == 32'd0);
    assign pc_out    = r_pc;
    assign link_addr = r_pc + 32'd8;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_RESET;
            r_pc           <= RESET_VECTOR;
            r_npc          <= RESET_VECTOR;
            r_pend         <= 32'd0;
            r_target_valid <= 1'b0;
            instr_address  <= RESET_VECTOR;
            instr_read     <= 1'b0;
            Instr          <= 32'd0;
            instr_valid    <= 1'b0;
            active         <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state       <= ST_FETCH;
                    active        <= 1'b1;
                    instr_read    <= 1'b1;
                    instr_address <= r_npc;
                end
                ST_FETCH: begin
                    if (!instr_waitrequest) begin
                        Instr       <= instr_readdata;
                        r_pc        <= r_npc;
                        instr_valid <= 1'b1;
                        instr_read  <= 1'b0;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        r_npc       <= w_next;
                        if (w_redirect) begin
                            r_pend         <= w_pend_next;
                            r_target_valid <= 1'b1;
                        end else begin
                            r_target_valid <= 1'b0;
                        end
                        if (w_halt) begin
                            r_state <= ST_HALTED;
                            active  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                            if (w_fault) begin
                                fetch_fault <= 1'b1;
                            end
`endif
                        end else begin
                            r_state       <= ST_FETCH;
                            instr_read    <= 1'b1;
                            instr_address <= w_next;
                        end
                    end
                end
                ST_HALTED: begin
                    active      <= 1'b0;
                    instr_read  <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: r_state <= ST_HALTED;
            endcase
        end
    end

endmodule
